linear_layer_start_token_reader: RTL



---
 rtl/linear_layer_start_token_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/linear_layer_start_token_reader.sv
// Consumer-side start-token reader: pops start tokens from a start_for_* FIFO and drives the PE start handshake.
// Optional sticky protocol-error detection is compiled in with `define START_READER_ERR_EN.
module linear_layer_start_token_reader #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  output logic [DATA_WIDTH-1:0] token,
  output logic [CNT_WIDTH-1:0]  inflight,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {S_IDLE, S_START} state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] token_q, token_d;
  logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
  logic                  accept;

  assign ap_start = (state_q == S_START);
  assign accept   = ap_start & ap_ready;
  assign token    = token_q;
  assign inflight = inflight_q;
  assign busy     = (state_q != S_IDLE) | (inflight_q != '0);

  // A done pulse at zero count pairs with a same-cycle acceptance, leaving the count unchanged.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !ap_done) begin
      inflight_d = inflight_q + ONE;
    end else if (!accept && ap_done && (inflight_q != '0)) begin
      inflight_d = inflight_q - ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    token_d = token_q;
    if_read = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_empty_n && (inflight_q < MAX_CNT) && reset_n) begin
          if_read = 1'b1;
          token_d = if_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        // Chaining looks at the post-update count so a same-cycle ap_done frees a slot.
        if (accept) begin
          if (if_empty_n && (inflight_d < MAX_CNT) && reset_n) begin
            if_read = 1'b1;
            token_d = if_dout;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      token_q    <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      token_q    <= token_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef START_READER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((ap_done && (inflight_q == '0) && !accept) || (ap_ready && !ap_start)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
